multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Parametrised, clocked successor to the combinational control decoder for the 3BC processor. It sequences each instruction through a fetch/decode/execute/memory/writeback state machine and drives the PC enable and register-file, data-memory and branch controls. It handshakes with a variable-latency data memory via MemReady, retires a halt instruction into a sticky Ack, and counts retired instructions. It sits between instrROM/ALU flags and program_counter/reg_file/DataMem.

Parameters:
IW, 9, instruction width in bits
OPW, 4, opcode field width; opcode = Instruction[IW-1 -: OPW]
WAIT_MAX, 8, maximum cycles spent in MEM waiting for MemReady before the error trap
CNT_W, 16, width of the retired-instruction counter (saturating)

Ports:
Clk  input  1  clock, rising edge
Reset  input  1  synchronous, active-high reset
Start  input  1  leaves IDLE and begins fetching
Instruction  input  IW  machine code from instrROM; sampled only in FETCH
Zero  input  1  ALU zero flag; sampled in EXEC
MemReady  input  1  data memory has completed the current read or write
PcEn  output  1  advance the PC (PC+1, or the branch target when Jump=1)
Jump  output  1  take the branch target this cycle
RegWrEn  output  1  reg_file write enable
RegLoadType  output  2  00 immediate, 01 DataMem, 10 ALU_out
MemRdEn  output  1  data memory read request
StoreInst  output  1  data memory write request
Ack  output  1  program done (halt retired); sticky
Err  output  1  memory timeout trap; sticky
InstrCount  output  CNT_W  number of retired instructions

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERR.
- Reset (synchronous, active-high): state=IDLE, IR=0, wait counter=0, InstrCount=0. All enables, Ack and Err are 0. RegLoadType=10. Reset overrides every state, including mid-MEM, HALT and ERR.
- Outputs are decoded from the state and IR, not from the live Instruction. The only exception is the FETCH capture.
- IDLE: all outputs 0. Start=1 moves to FETCH on the next edge.
- FETCH: one cycle. IR<=Instruction at the end of the cycle. Next state is DECODE.
- DECODE: one cycle, no enables. Transitions:
  - IR all ones (kHALT) goes to HALT.
  - opcode kLDR or kSTR goes to MEM, with the wait counter cleared.
  - any other opcode goes to EXEC.
- EXEC: one cycle. Then PcEn=1 and the FSM returns to FETCH.
  - RegWrEn=1 for the writeback class: every opcode except kSTR, kBRZ, kNOP and kHALT.
  - RegLoadType=00 for kLDI, otherwise 10.
  - Jump=1 when opcode is kBRZ and Zero=1. kBRZ with Zero=0 advances the PC normally.
- MEM: MemRdEn=1 (kLDR) or StoreInst=1 (kSTR), held every cycle until exit.
  - MemReady=1 for kLDR: go to WB.
  - MemReady=1 for kSTR: PcEn=1 in this same cycle, then go to FETCH.
  - MemReady=0: wait counter increments. When the counter reaches WAIT_MAX with no MemReady, go to ERR. At most WAIT_MAX cycles are spent in MEM before the trap.
- WB: one cycle. RegWrEn=1, RegLoadType=01, PcEn=1. Next state is FETCH.
- HALT: Ack=1 and all enables 0. Sticky until Reset; Start is ignored.
- ERR: Err=1 and all enables 0. Sticky until Reset.
- Retirement: InstrCount increments once per instruction on its PcEn cycle, and once on entry to HALT. It saturates at all ones.
- Cycle counts from FETCH to the next FETCH:
  - ALU, kLDI, kBRZ: 3 cycles.
  - kSTR: 2 + n cycles.
  - kLDR: 3 + n cycles.
  - n is the number of MEM cycles, 1 ≤ n ≤ WAIT_MAX.
- Mutual exclusion: MemRdEn and StoreInst are never high together. PcEn is high for exactly one cycle per retired instruction. Jump implies PcEn.

Decomposition:
- Shared package (definitions) holds:
  - the opcode constants: kLDI, kLDR, kSTR, kBRZ, kNOP and the ALU opcodes; kHALT = all ones.
  - the RegLoadType encodings (kLT_IMM=00, kLT_MEM=01, kLT_ALU=10).
  - the state enum type.
- One sub-module, ctrl_decode: combinational mapping from opcode to class flags (is_wb, is_ld, is_st, is_br, is_ldi, is_halt). The FSM in multicycle_ctrl consumes these flags.

Test Plan:
- Reset, pulse Start, Instruction=ALU add (opcode 0000) → PcEn high exactly in cycle 3 after FETCH; RegWrEn=1, RegLoadType=10 in that cycle; InstrCount=1.
- kLDR, MemReady held low 3 cycles then high → MemRdEn high 4 cycles; WB cycle has RegWrEn=1, RegLoadType=01, PcEn=1; StoreInst never high.
- kSTR with MemReady high on the first MEM cycle → StoreInst and PcEn high together for 1 cycle, RegWrEn=0; next FETCH 3 cycles after the previous FETCH.
- kBRZ with Zero=1, then kBRZ with Zero=0 → first gives Jump=1 with PcEn=1; second gives Jump=0 with PcEn=1; RegWrEn=0 for both.
- kLDR with MemReady never asserted, WAIT_MAX=8 → ERR entered after 8 MEM cycles; Err=1 and enables 0 stay sticky; Reset returns to IDLE with Err=0.
- Instruction 9'h1FF → Ack=1 from the cycle after DECODE, Start toggling ignored, InstrCount incremented once; Reset asserted during HALT and during a MEM wait → IDLE, all outputs at reset values.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle controller: opcode map, register-file
// load-source encodings and the sequencer state type.
package multicycle_ctrl_pkg;

    localparam logic [3:0] kADD  = 4'b0000;
    localparam logic [3:0] kSUB  = 4'b0001;
    localparam logic [3:0] kAND  = 4'b0010;
    localparam logic [3:0] kOR   = 4'b0011;
    localparam logic [3:0] kXOR  = 4'b0100;
    localparam logic [3:0] kSLL  = 4'b0101;
    localparam logic [3:0] kSRL  = 4'b0110;
    localparam logic [3:0] kMOV  = 4'b0111;
    localparam logic [3:0] kLDI  = 4'b1000;
    localparam logic [3:0] kLDR  = 4'b1001;
    localparam logic [3:0] kSTR  = 4'b1010;
    localparam logic [3:0] kBRZ  = 4'b1011;
    localparam logic [3:0] kNOP  = 4'b1100;
    localparam logic [3:0] kINC  = 4'b1101;
    localparam logic [3:0] kDEC  = 4'b1110;
    // A real halt is the whole instruction word set to ones; this is its opcode field.
    localparam logic [3:0] kHALT = 4'b1111;

    localparam logic [1:0] kLT_IMM = 2'b00;
    localparam logic [1:0] kLT_MEM = 2'b01;
    localparam logic [1:0] kLT_ALU = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT,
        S_ERR
    } state_e;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational instruction classifier: maps the latched instruction word onto
// the class flags the sequencer branches on.
module ctrl_decode #(
    parameter int IW  = 9,
    parameter int OPW = 4
) (
    input  logic [IW-1:0] instr,
    output logic          is_wb,
    output logic          is_ld,
    output logic          is_st,
    output logic          is_br,
    output logic          is_ldi,
    output logic          is_halt
);
    import multicycle_ctrl_pkg::*;

    logic [OPW-1:0] op;
    logic           is_nop;
    logic           is_halt_op;

    assign op = instr[IW-1 -: OPW];

    always_comb begin
        is_halt    = &instr;
        is_ld      = (op == OPW'(kLDR));
        is_st      = (op == OPW'(kSTR));
        is_br      = (op == OPW'(kBRZ));
        is_ldi     = (op == OPW'(kLDI));
        is_nop     = (op == OPW'(kNOP));
        // The halt opcode never writes back, even when the operand bits are not all ones.
        is_halt_op = (op == OPW'(kHALT));
        is_wb      = !(is_st || is_br || is_nop || is_halt_op);
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle instruction sequencer for the 3BC processor: FETCH/DECODE/EXEC/MEM/WB
// with a variable-latency memory handshake, sticky halt/error and a retire counter.
module multicycle_ctrl #(
    parameter int IW       = 9,
    parameter int OPW      = 4,
    parameter int WAIT_MAX = 8,
    parameter int CNT_W    = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [IW-1:0]    Instruction,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             PcEn,
    output logic             Jump,
    output logic             RegWrEn,
    output logic [1:0]       RegLoadType,
    output logic             MemRdEn,
    output logic             StoreInst,
    output logic             Ack,
    output logic             Err,
    output logic [CNT_W-1:0] InstrCount
);
    import multicycle_ctrl_pkg::*;

    localparam int WC_W = $clog2(WAIT_MAX + 1);

    state_e            state_q, state_d;
    logic [IW-1:0]     ir_q, ir_d;
    logic [WC_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              retire;

    logic is_wb, is_ld, is_st, is_br, is_ldi, is_halt;

    ctrl_decode #(
        .IW  (IW),
        .OPW (OPW)
    ) u_decode (
        .instr   (ir_q),
        .is_wb   (is_wb),
        .is_ld   (is_ld),
        .is_st   (is_st),
        .is_br   (is_br),
        .is_ldi  (is_ldi),
        .is_halt (is_halt)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            wait_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        wait_d      = wait_q;
        PcEn        = 1'b0;
        Jump        = 1'b0;
        RegWrEn     = 1'b0;
        RegLoadType = kLT_ALU;
        MemRdEn     = 1'b0;
        StoreInst   = 1'b0;
        Ack         = 1'b0;
        Err         = 1'b0;
        retire      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Start) state_d = S_FETCH;
            end
            S_FETCH: begin
                ir_d    = Instruction;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_halt) begin
                    state_d = S_HALT;
                    retire  = 1'b1;
                end else if (is_ld || is_st) begin
                    state_d = S_MEM;
                    wait_d  = '0;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                PcEn        = 1'b1;
                RegWrEn     = is_wb;
                RegLoadType = is_ldi ? kLT_IMM : kLT_ALU;
                Jump        = is_br && Zero;
                state_d     = S_FETCH;
            end
            S_MEM: begin
                MemRdEn   = is_ld;
                StoreInst = is_st;
                if (MemReady) begin
                    // Stores retire in the handshake cycle; loads still need a writeback.
                    if (is_st) begin
                        PcEn    = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                    if (wait_q == WC_W'(WAIT_MAX - 1)) state_d = S_ERR;
                end
            end
            S_WB: begin
                RegWrEn     = 1'b1;
                RegLoadType = kLT_MEM;
                PcEn        = 1'b1;
                state_d     = S_FETCH;
            end
            S_HALT: begin
                Ack = 1'b1;
            end
            S_ERR: begin
                Err = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (PcEn) retire = 1'b1;
        cnt_d = (retire && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    end

    assign InstrCount = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios with literal
// expectations plus randomized instruction streams against a timeline model.
module tb_multicycle_ctrl;
    localparam int IW       = 9;
    localparam int WAIT_MAX = 8;
    localparam int CNT_W    = 5;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             Reset = 1'b1;
    logic             Start = 1'b0;
    logic [IW-1:0]    Instruction = '0;
    logic             Zero = 1'b0;
    logic             MemReady = 1'b0;
    logic             PcEn, Jump, RegWrEn, MemRdEn, StoreInst, Ack, Err;
    logic [1:0]       RegLoadType;
    logic [CNT_W-1:0] InstrCount;

    always #5 clk = ~clk;

    multicycle_ctrl #(
        .IW       (IW),
        .OPW      (4),
        .WAIT_MAX (WAIT_MAX),
        .CNT_W    (CNT_W)
    ) dut (
        .Clk         (clk),
        .Reset       (Reset),
        .Start       (Start),
        .Instruction (Instruction),
        .Zero        (Zero),
        .MemReady    (MemReady),
        .PcEn        (PcEn),
        .Jump        (Jump),
        .RegWrEn     (RegWrEn),
        .RegLoadType (RegLoadType),
        .MemRdEn     (MemRdEn),
        .StoreInst   (StoreInst),
        .Ack         (Ack),
        .Err         (Err),
        .InstrCount  (InstrCount)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Instruction class: 0 ALU writeback, 1 LDI, 2 LDR, 3 STR, 4 BRZ, 5 no-writeback, 6 halt
    function automatic int kind(input logic [IW-1:0] i);
        if (i == 9'h1FF) return 6;
        case (i[8:5])
            4'b1000: return 1;
            4'b1001: return 2;
            4'b1010: return 3;
            4'b1011: return 4;
            4'b1100, 4'b1111: return 5;
            default: return 0;
        endcase
    endfunction

    // Timeline model: mode 0 idle, 1 running, 2 halted, 3 trapped.
    // m_t counts cycles since the current instruction's fetch cycle.
    int          m_mode = 0;
    int          m_t = 0;
    int          m_memk = 0;
    bit          m_wbp = 0;
    int          m_cnt = 0;
    bit          m_valid = 0;
    logic [IW-1:0] m_ir = '0;

    initial begin : compare
        logic e_pc, e_j, e_wr, e_rd, e_st;
        logic [1:0] e_lt;
        int k;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                e_pc = 0; e_j = 0; e_wr = 0; e_rd = 0; e_st = 0; e_lt = 2'b10;
                if (m_mode == 1 && m_t >= 2) begin
                    k = kind(m_ir);
                    if (k == 2 || k == 3) begin
                        if (m_wbp) begin
                            e_wr = 1; e_lt = 2'b01; e_pc = 1;
                        end else begin
                            e_rd = (k == 2);
                            e_st = (k == 3);
                            e_pc = (k == 3) && MemReady;
                        end
                    end else begin
                        e_pc = 1;
                        e_wr = (k == 0 || k == 1);
                        e_lt = (k == 1) ? 2'b00 : 2'b10;
                        e_j  = (k == 4) && Zero;
                    end
                end
                check("PcEn", 32'(PcEn), 32'(e_pc));
                check("Jump", 32'(Jump), 32'(e_j));
                check("RegWrEn", 32'(RegWrEn), 32'(e_wr));
                check("RegLoadType", 32'(RegLoadType), 32'(e_lt));
                check("MemRdEn", 32'(MemRdEn), 32'(e_rd));
                check("StoreInst", 32'(StoreInst), 32'(e_st));
                check("Ack", 32'(Ack), 32'(m_mode == 2));
                check("Err", 32'(Err), 32'(m_mode == 3));
                check("InstrCount", 32'(InstrCount), 32'(m_cnt));
            end
            @(posedge clk);
            if (Reset) begin
                m_mode = 0; m_cnt = 0; m_ir = '0; m_valid = 1;
            end else if (m_mode == 0) begin
                if (Start) begin m_mode = 1; m_t = 0; end
            end else if (m_mode == 1) begin
                k = kind(m_ir);
                if (m_t == 0) begin
                    m_ir = Instruction; m_t = 1;
                end else if (m_t == 1) begin
                    if (kind(m_ir) == 6) begin
                        m_mode = 2;
                        if (m_cnt < CNT_MAX) m_cnt++;
                    end else begin
                        m_t = 2; m_memk = 0; m_wbp = 0;
                    end
                end else if ((k == 2 || k == 3) && !m_wbp && !MemReady) begin
                    m_memk++; m_t++;
                    if (m_memk == WAIT_MAX) m_mode = 3;
                end else if (k == 2 && !m_wbp) begin
                    m_wbp = 1; m_t++;
                end else begin
                    if (m_cnt < CNT_MAX) m_cnt++;
                    m_t = 0;
                end
            end
        end
    end

    // Stimulus-side samples of the current cycle's outputs
    logic             s_pc, s_j, s_wr, s_rd, s_st, s_ack, s_err;
    logic [1:0]       s_lt;
    logic [CNT_W-1:0] s_cnt;

    task automatic cyc();
        @(negedge clk);
        s_pc = PcEn; s_j = Jump; s_wr = RegWrEn; s_rd = MemRdEn; s_st = StoreInst;
        s_ack = Ack; s_err = Err; s_lt = RegLoadType; s_cnt = InstrCount;
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        Reset = 1; Start = 0;
        cyc();
        Reset = 0; Start = 1;
        cyc();
        Start = 0;
    endtask

    int          r_len, r_rd, r_st, r_wr, r_pc, r_jp;
    logic [1:0]  r_lt;
    logic [31:0] r_cnt0;

    // Runs one instruction from its FETCH cycle; n is the MEM cycle on which
    // MemReady first rises (0 = never). Stops at retirement or after budget cycles.
    task automatic do_instr(input logic [IW-1:0] ins, input int n, input logic z, input int budget);
        bit is_mem = (ins[8:5] == 4'b1001) || (ins[8:5] == 4'b1010);
        r_len = 0; r_rd = 0; r_st = 0; r_wr = 0; r_pc = 0; r_jp = 0; r_lt = 2'b11;
        Instruction = ins; Zero = z; MemReady = 1'($urandom);
        cyc();
        r_cnt0 = 32'(s_cnt);
        Instruction = IW'($urandom);
        for (int t = 1; t < budget; t++) begin
            MemReady = is_mem ? ((n > 0) && (t >= 1 + n)) : 1'($urandom);
            cyc();
            r_rd += int'(s_rd); r_st += int'(s_st); r_wr += int'(s_wr);
            r_pc += int'(s_pc); r_jp += int'(s_j);
            if (s_pc) begin
                r_lt = s_lt; r_len = t + 1;
                break;
            end
        end
    endtask

    initial begin : stimulus
        logic [3:0] op;
        int n, exp_len;
        logic [IW-1:0] ins;

        restart();

        do_instr(9'h000, 0, 0, 10);
        $display("ADD: len=%0d pc=%0d wr=%0d lt=%0d", r_len, r_pc, r_wr, r_lt);
        check("add_len", r_len, 3); check("add_pc", r_pc, 1);
        check("add_wr", r_wr, 1); check("add_lt", 32'(r_lt), 2); check("add_rd_st", r_rd + r_st, 0);

        do_instr({4'b1001, 5'h0A}, 4, 0, 14);
        $display("LDR n=4: len=%0d rd=%0d st=%0d wr=%0d lt=%0d", r_len, r_rd, r_st, r_wr, r_lt);
        check("add_count", r_cnt0, 1);
        check("ldr_len", r_len, 7); check("ldr_rd", r_rd, 4); check("ldr_st", r_st, 0);
        check("ldr_wr", r_wr, 1); check("ldr_lt", 32'(r_lt), 1); check("ldr_pc", r_pc, 1);

        do_instr({4'b1010, 5'h03}, 1, 0, 14);
        $display("STR n=1: len=%0d st=%0d wr=%0d pc=%0d", r_len, r_st, r_wr, r_pc);
        check("str_count", r_cnt0, 2);
        check("str_len", r_len, 3); check("str_st", r_st, 1); check("str_wr", r_wr, 0);
        check("str_pc", r_pc, 1);

        do_instr({4'b1011, 5'h11}, 0, 1, 10);
        $display("BRZ z=1: jump=%0d pc=%0d wr=%0d", r_jp, r_pc, r_wr);
        check("brz1_jump", r_jp, 1); check("brz1_pc", r_pc, 1); check("brz1_wr", r_wr, 0);
        check("brz1_len", r_len, 3);

        do_instr({4'b1011, 5'h11}, 0, 0, 10);
        $display("BRZ z=0: jump=%0d pc=%0d wr=%0d", r_jp, r_pc, r_wr);
        check("brz0_jump", r_jp, 0); check("brz0_pc", r_pc, 1); check("brz0_wr", r_wr, 0);

        do_instr({4'b1000, 5'h07}, 0, 0, 10);
        $display("LDI: wr=%0d lt=%0d", r_wr, r_lt);
        check("ldi_wr", r_wr, 1); check("ldi_lt", 32'(r_lt), 0);

        do_instr({4'b1100, 5'h00}, 0, 0, 10);
        $display("NOP: wr=%0d len=%0d count_at_fetch=%0d", r_wr, r_len, r_cnt0);
        check("nop_wr", r_wr, 0); check("nop_len", r_len, 3); check("nop_count", r_cnt0, 6);

        do_instr(9'h1FF, 0, 0, 4);
        $display("HALT: ack=%0d count=%0d pc=%0d", s_ack, s_cnt, r_pc);
        check("halt_pc", r_pc, 0); check("halt_ack", 32'(s_ack), 1);
        check("halt_count", 32'(s_cnt), 8);
        Start = 1; cyc();
        check("halt_start_ack", 32'(s_ack), 1); check("halt_start_count", 32'(s_cnt), 8);
        Start = 0; cyc();
        check("halt_sticky", 32'(s_ack), 1);
        Reset = 1; cyc(); Reset = 0; cyc();
        $display("RESET in HALT: ack=%0d count=%0d lt=%0d", s_ack, s_cnt, s_lt);
        check("halt_rst_ack", 32'(s_ack), 0); check("halt_rst_count", 32'(s_cnt), 0);
        check("halt_rst_lt", 32'(s_lt), 2);

        restart();
        do_instr({4'b1001, 5'h01}, 0, 0, 10);
        cyc();
        $display("LDR timeout: rd=%0d err=%0d", r_rd, s_err);
        check("to_rd", r_rd, WAIT_MAX); check("to_len", r_len, 0);
        check("to_err", 32'(s_err), 1); check("to_rd_after", 32'(s_rd), 0);
        Start = 1; MemReady = 1; cyc();
        check("to_err_sticky", 32'(s_err), 1); check("to_pc", 32'(s_pc), 0);
        Start = 0; Reset = 1; cyc(); Reset = 0; cyc();
        $display("RESET in ERR: err=%0d", s_err);
        check("to_rst_err", 32'(s_err), 0);

        restart();
        do_instr({4'b1001, 5'h02}, 0, 0, 4);
        Reset = 1; cyc();
        check("mem_rst_rd_before", 32'(s_rd), 1);
        Reset = 0; cyc();
        $display("RESET in MEM: rd=%0d pc=%0d count=%0d lt=%0d", s_rd, s_pc, s_cnt, s_lt);
        check("mem_rst_rd", 32'(s_rd), 0); check("mem_rst_count", 32'(s_cnt), 0);
        check("mem_rst_lt", 32'(s_lt), 2); check("mem_rst_err", 32'(s_err), 0);

        restart();
        for (int i = 0; i < CNT_MAX + 3; i++) do_instr({4'b1100, 5'h00}, 0, 0, 10);
        do_instr({4'b1100, 5'h00}, 0, 0, 10);
        $display("SATURATION: count_at_fetch=%0d", r_cnt0);
        check("count_sat", r_cnt0, CNT_MAX);

        restart();
        for (int i = 0; i < 300; i++) begin
            n = $urandom_range(0, 39);
            if (n == 0) begin
                do_instr(9'h1FF, 0, 0, 4);
                $display("rand %0d: HALT ack=%0d", i, s_ack);
                check("rand_halt_ack", 32'(s_ack), 1);
                restart();
            end else if (n == 1) begin
                ins = {($urandom_range(0, 1) != 0) ? 4'b1001 : 4'b1010, 5'($urandom)};
                do_instr(ins, 0, 0, 10);
                cyc();
                $display("rand %0d: timeout ins=%03h err=%0d", i, ins, s_err);
                check("rand_err", 32'(s_err), 1);
                restart();
            end else begin
                op = 4'($urandom_range(0, 14));
                ins = {op, 5'($urandom)};
                n = $urandom_range(1, WAIT_MAX);
                do_instr(ins, n, 1'($urandom), 20);
                exp_len = (op == 4'b1001) ? 3 + n : (op == 4'b1010) ? 2 + n : 3;
                $display("rand %0d: ins=%03h n=%0d len=%0d", i, ins, n, r_len);
                check("rand_len", r_len, exp_len);
                check("rand_pc_once", r_pc, 1);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
